// File: rtl/xadc_oversample4.sv
// Oversampling ADC front-end: counts ones of a synchronised 1-bit input
// over a fixed window of clock cycles and holds the count as a code.
module xadc_oversample4 #(
    parameter int OUT_W       = 4,
    parameter int WINDOW      = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic vin,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3
);

    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_wcnt;
    logic [OUT_W-1:0]       r_acc;
    logic [OUT_W-1:0]       r_code;
    logic [OUT_W-1:0]       w_sum;
    logic                   w_s;
    logic                   w_last;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_sum  = r_acc + OUT_W'(w_s);
    assign w_last = (r_wcnt == LAST);

    // vin is asynchronous to clock; only the last stage is consumed
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], vin};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wcnt <= '0;
            r_acc  <= '0;
            r_code <= '0;
        end else if (w_last) begin
            r_code <= w_sum;
            r_acc  <= '0;
            r_wcnt <= '0;
        end else begin
            r_acc  <= w_sum;
            r_wcnt <= r_wcnt + 1'b1;
        end
    end

    assign d0 = r_code[0];
    assign d1 = r_code[1];
    assign d2 = r_code[2];
    assign d3 = r_code[3];

endmodule

// File: tb/tb_xadc_oversample4.sv
// Directed bench for xadc_oversample4: reset, constant, step,
// alternating and mid-window reset stimulus with hand-computed codes.
`timescale 1ns/1ps
module tb_xadc_oversample4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       vin = 1'b0;
    logic       d0, d1, d2, d3;
    logic [3:0] code;
    int         total = 0;
    int         passed = 0;

    assign code = {d3, d2, d1, d0};

    always #100 clock = ~clock;

    xadc_oversample4 #(
        .OUT_W(4),
        .WINDOW(15),
        .SYNC_STAGES(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .vin(vin),
        .d0(d0),
        .d1(d1),
        .d2(d2),
        .d3(d3)
    );

    // Reset is asserted and released on falling edges, so edge 1 is the
    // first rising edge after release.
    task automatic apply_reset(input logic v);
        @(negedge clock);
        reset_n = 1'b0;
        vin = v;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clock);
        reset_n = 1'b0;
        vin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            total++;
            if (code !== 4'd0)
                $display("FAIL reset_hold cyc%0d: got %b want 0000", i, code);
            else
                passed++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            edges(1);
            total++;
            if (code !== 4'd0)
                $display("FAIL reset_rel edge%0d: got %b want 0000", e, code);
            else
                passed++;
        end
        // first two samples come from the cleared synchroniser
        edges(1);
        total++;
        if (code !== 4'd13)
            $display("FAIL reset_first_win: got %b want 1101", code);
        else
            passed++;
    endtask

    task automatic test_all_zero;
        apply_reset(1'b0);
        for (int w = 1; w <= 4; w++) begin
            edges(15);
            total++;
            if (code !== 4'd0)
                $display("FAIL all_zero win%0d: got %b want 0000", w, code);
            else
                passed++;
        end
    endtask

    task automatic test_all_one;
        logic [3:0] exp;
        apply_reset(1'b1);
        for (int w = 1; w <= 4; w++) begin
            exp = (w == 1) ? 4'd13 : 4'd15;
            edges(15);
            total++;
            if (code !== exp)
                $display("FAIL all_one win%0d: got %b want %b", w, code, exp);
            else
                passed++;
        end
    endtask

    // vin rises after edge m; samples at edges 1..m+2 read 0
    task automatic test_step;
        int steps [2] = '{5, 11};
        int k;
        logic [3:0] exp;
        for (int t = 0; t < 2; t++) begin
            apply_reset(1'b0);
            repeat (steps[t]) @(posedge clock);
            @(negedge clock);
            vin = 1'b1;
            k = steps[t] + 2;
            exp = 4'(15 - k);
            edges(15 - steps[t]);
            total++;
            if (code !== exp)
                $display("FAIL step m%0d win1: got %0d want %0d",
                         steps[t], code, exp);
            else
                passed++;
            for (int w = 2; w <= 3; w++) begin
                edges(15);
                total++;
                if (code !== 4'd15)
                    $display("FAIL step m%0d win%0d: got %0d want 15",
                             steps[t], w, code);
                else
                    passed++;
            end
        end
    endtask

    // vin is 1 on even edges; sample at edge n is vin from edge n-2
    task automatic test_alternating;
        int exp [5] = '{6, 8, 7, 8, 7};
        apply_reset(1'b0);
        for (int e = 1; e <= 75; e++) begin
            @(posedge clock);
            #1;
            if (e % 15 == 0) begin
                total++;
                if (code !== 4'(exp[e/15-1]))
                    $display("FAIL alt win%0d: got %0d want %0d",
                             e / 15, code, exp[e/15-1]);
                else
                    passed++;
            end
            @(negedge clock);
            vin = ~vin;
        end
    endtask

    task automatic test_mid_window_reset;
        apply_reset(1'b1);
        edges(15);
        total++;
        if (code !== 4'd13)
            $display("FAIL midrst pre: got %b want 1101", code);
        else
            passed++;
        edges(7);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        total++;
        if (code !== 4'd0)
            $display("FAIL midrst async: got %b want 0000", code);
        else
            passed++;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        edges(14);
        total++;
        if (code !== 4'd0)
            $display("FAIL midrst edge14: got %b want 0000", code);
        else
            passed++;
        edges(1);
        total++;
        if (code !== 4'd13)
            $display("FAIL midrst edge15: got %b want 1101", code);
        else
            passed++;
        edges(15);
        total++;
        if (code !== 4'd15)
            $display("FAIL midrst edge30: got %b want 1111", code);
        else
            passed++;
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_all_one();
        test_step();
        test_alternating();
        test_mid_window_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
